// File: rtl/recip_unit.sv
// recip_unit: computes Q = floor(32768 / D) for a 16-bit divisor read from data memory
// and writes the 16-bit result back. D = 0 saturates to 16'hFFFF.
// Optional macro RECIP_ROUND_EN: adds a 17th divide step for one fraction bit and
// rounds the result half-LSB upward.
module recip_unit #(
  parameter int unsigned DIVISOR_ADDR = 8,
  parameter int unsigned RESULT_ADDR  = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic       Busy,
  output logic [7:0] MemAddr,
  input  logic [7:0] MemRdData,
  output logic       MemWrEn,
  output logic [7:0] MemWrData
);

`ifdef RECIP_ROUND_EN
  localparam int unsigned Iters = 17;
`else
  localparam int unsigned Iters = 16;
`endif

  typedef enum logic [2:0] {
    StIdle, StLdHi, StLdLo, StCheck, StDiv, StStHi, StStLo, StDone
  } state_e;

  state_e             state_q;
  logic               start_q;  // Start sampled on the previous edge
  logic               armed_q;  // Start seen high since reset
  logic [15:0]        d_q;
  logic [16:0]        rem_q;
  logic [Iters-1:0]   quot_q;
  logic [15:0]        num_q;
  logic [4:0]         cnt_q;
  logic [15:0]        res_q;

  logic [16:0]        rem_shift;
  logic [16:0]        rem_next;
  logic               qbit;
  logic [Iters-1:0]   quot_next;
  logic [15:0]        res_final;
  logic               last_iter;
  logic               launch;

  // One restoring-division step plus final result formation
  always_comb begin
    rem_shift = 17'({rem_q, num_q[15]});
    qbit      = 1'b0;
    rem_next  = rem_shift;
    if (rem_shift >= {1'b0, d_q}) begin
      qbit     = 1'b1;
      rem_next = rem_shift - {1'b0, d_q};
    end
    quot_next = Iters'({quot_q, qbit});
`ifdef RECIP_ROUND_EN
    // quot_next[0] is the first fraction bit
    res_final = quot_next[16:1] + {15'd0, quot_next[0]};
`else
    res_final = quot_next;
`endif
    last_iter = (cnt_q == 5'(Iters - 1));
    launch    = armed_q && start_q && !Start;
  end

  // Control FSM with registered memory-side outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      start_q   <= 1'b1;
      armed_q   <= 1'b0;
      d_q       <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      num_q     <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      Ack       <= 1'b0;
      Busy      <= 1'b0;
      MemAddr   <= '0;
      MemWrEn   <= 1'b0;
      MemWrData <= '0;
    end else begin
      start_q <= Start;
      if (Start) armed_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (launch) begin
            state_q <= StLdHi;
            Busy    <= 1'b1;
            MemAddr <= 8'(DIVISOR_ADDR);
          end
        end
        StLdHi: begin
          d_q[15:8] <= MemRdData;
          MemAddr   <= 8'(DIVISOR_ADDR + 1);
          state_q   <= StLdLo;
        end
        StLdLo: begin
          d_q[7:0] <= MemRdData;
          MemAddr  <= '0;
          state_q  <= StCheck;
        end
        StCheck: begin
          if (d_q == 16'd0) begin
            res_q     <= 16'hFFFF;
            MemAddr   <= 8'(RESULT_ADDR);
            MemWrEn   <= 1'b1;
            MemWrData <= 8'hFF;
            state_q   <= StStHi;
          end else begin
            rem_q   <= '0;
            quot_q  <= '0;
            num_q   <= 16'h8000;
            cnt_q   <= '0;
            state_q <= StDiv;
          end
        end
        StDiv: begin
          rem_q  <= rem_next;
          quot_q <= quot_next;
          num_q  <= num_q << 1;
          cnt_q  <= cnt_q + 5'd1;
          if (last_iter) begin
            res_q     <= res_final;
            MemAddr   <= 8'(RESULT_ADDR);
            MemWrEn   <= 1'b1;
            MemWrData <= res_final[15:8];
            state_q   <= StStHi;
          end
        end
        StStHi: begin
          MemAddr   <= 8'(RESULT_ADDR + 1);
          MemWrData <= res_q[7:0];
          state_q   <= StStLo;
        end
        StStLo: begin
          MemAddr   <= '0;
          MemWrEn   <= 1'b0;
          MemWrData <= '0;
          Busy      <= 1'b0;
          Ack       <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          if (Start) begin
            Ack     <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_recip_unit.sv
// Scoreboard bench for recip_unit: stimulus pushes expected results, a monitor
// checks result bytes, latency and write count when Ack rises.
module tb_recip_unit;

  localparam int DivAddr = 8;
  localparam int ResAddr = 10;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Ack;
  logic       Busy;
  logic [7:0] MemAddr;
  logic [7:0] MemRdData;
  logic       MemWrEn;
  logic [7:0] MemWrData;

  logic [15:0] tb_div = 16'd0;
  logic [7:0]  mem [256];

  int cyc      = 0;
  int wr_total = 0;
  int total    = 0;
  int bad      = 0;

  typedef struct {
    logic [15:0] d;
    logic [15:0] q;
    int          lat;
    int          t0;
    int          wr0;
  } exp_t;

  exp_t sb[$];

  recip_unit #(
    .DIVISOR_ADDR(DivAddr),
    .RESULT_ADDR (ResAddr)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Ack      (Ack),
    .Busy     (Busy),
    .MemAddr  (MemAddr),
    .MemRdData(MemRdData),
    .MemWrEn  (MemWrEn),
    .MemWrData(MemWrData)
  );

  always #5 Clk = ~Clk;

  assign MemRdData = (MemAddr == 8'(DivAddr))     ? tb_div[15:8] :
                     (MemAddr == 8'(DivAddr + 1)) ? tb_div[7:0]  : mem[MemAddr];

  always @(posedge Clk) begin
    if (MemWrEn) mem[MemAddr] <= MemWrData;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: plain integer arithmetic on the reciprocal definition
  function automatic logic [15:0] ref_q(logic [15:0] d);
    int unsigned dd;
    int unsigned n;
    dd = d;
    if (dd == 0) return 16'hFFFF;
`ifdef RECIP_ROUND_EN
    n = ((65536 / dd) + 1) / 2;
`else
    n = 32768 / dd;
`endif
    return n[15:0];
  endfunction

  function automatic int ref_lat(logic [15:0] d);
    if (d == 16'd0) return 5;
`ifdef RECIP_ROUND_EN
    return 22;
`else
    return 21;
`endif
  endfunction

  // Monitor: count writes, check a result whenever Ack rises
  initial begin
    logic ack_prev;
    exp_t e;
    ack_prev = 1'b0;
    forever begin
      @(negedge Clk);
      if (MemWrEn) wr_total++;
      if (Ack && !ack_prev) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got ack with empty scoreboard (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk($sformatf("result d=%0h", e.d), {16'd0, mem[ResAddr], mem[ResAddr + 1]},
              {16'd0, e.q});
          chk($sformatf("latency d=%0h", e.d), cyc - e.t0, e.lat);
          chk($sformatf("writes d=%0h", e.d), wr_total - e.wr0, 2);
        end
      end
      ack_prev = Ack;
    end
  end

  // Start high then low; from DONE the high phase also releases Ack
  task automatic run(input logic [15:0] d, input bit push, input bit toggle);
    exp_t e;
    logic was_ack;
    tb_div = d;
    @(negedge Clk);
    was_ack = Ack;
    Start = 1'b1;
    @(negedge Clk);
    if (was_ack) chk("ack_release", {31'd0, Ack}, 0);
    Start = 1'b0;
    if (push) begin
      e.d   = d;
      e.q   = ref_q(d);
      e.lat = ref_lat(d);
      e.t0  = cyc + 1;
      e.wr0 = wr_total;
      sb.push_back(e);
    end
    if (toggle) begin
      repeat (2) @(negedge Clk);
      for (int i = 0; i < 6; i++) begin
        @(negedge Clk);
        Start = ~Start;
      end
      Start = 1'b0;
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge Clk);
      if (Ack) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: got no ack expected ack within 200 cycles");
    end else begin
      repeat (3) @(negedge Clk);
      chk("ack_hold", {31'd0, Ack}, 1);
      chk("busy_done", {31'd0, Busy}, 0);
    end
  endtask

  initial begin
    logic [15:0] d;
    logic [7:0]  m_hi;
    logic [7:0]  m_lo;
    int          w0;
    logic [15:0] dirs [7];
    dirs[0] = 16'd3;
    dirs[1] = 16'd1;
    dirs[2] = 16'd4;
    dirs[3] = 16'h8000;
    dirs[4] = 16'hFFFF;
    dirs[5] = 16'd0;
    dirs[6] = 16'd2;

    Reset = 1'b0;
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_ack", {31'd0, Ack}, 0);
    chk("rst_busy", {31'd0, Busy}, 0);
    chk("rst_wren", {31'd0, MemWrEn}, 0);
    chk("rst_addr", {24'd0, MemAddr}, 0);
    chk("rst_wdata", {24'd0, MemWrData}, 0);
    Reset = 1'b1;
    repeat (4) @(negedge Clk);
    chk("no_launch_after_reset", {31'd0, Busy}, 0);

    for (int i = 0; i < 7; i++) begin
      run(dirs[i], 1'b1, 1'b0);
      wait_done();
    end

    // Start activity while busy must not disturb result or latency
    run(16'd3, 1'b1, 1'b1);
    wait_done();

    // Abort mid-divide
    run(16'd7, 1'b0, 1'b0);
    repeat (8) @(negedge Clk);
    chk("div_busy", {31'd0, Busy}, 1);
    m_hi = mem[ResAddr];
    m_lo = mem[ResAddr + 1];
    w0   = wr_total;
    Reset = 1'b0;
    #1;
    chk("abort_ack", {31'd0, Ack}, 0);
    chk("abort_busy", {31'd0, Busy}, 0);
    chk("abort_wren", {31'd0, MemWrEn}, 0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (30) @(negedge Clk);
    chk("abort_idle", {31'd0, Busy}, 0);
    chk("abort_noack", {31'd0, Ack}, 0);
    chk("abort_writes", wr_total - w0, 0);
    chk("abort_mem", {16'd0, mem[ResAddr], mem[ResAddr + 1]}, {16'd0, m_hi, m_lo});
    run(16'd7, 1'b1, 1'b0);
    wait_done();

    for (int i = 0; i < 16; i++) begin
      if (i % 5 == 4) d = 16'd0;
      else if (i % 2 == 0) d = 16'($urandom_range(1, 300));
      else d = 16'($urandom_range(1, 65535));
      run(d, 1'b1, i % 3 == 1 && d != 16'd0);
      wait_done();
    end

    repeat (5) @(negedge Clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1);
  end

endmodule
